seg_scan_ctrl: RTL and testbench

//  Scan scheduler for the shared 6-digit, 7-segment bus (seg_sel/seg_led) at clk_50M.

---
 rtl/seg_scan_ctrl_pkg.sv | 29 ++
 rtl/seg_scan_ctrl_hex.sv | 35 +++
 rtl/seg_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 6-digit seven-segment scan controller.
// Digit store entries, FSM encoding and the one-cold select helper.
package seg_scan_ctrl_pkg;

  localparam int NUM_DIG = 6;
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [NUM_DIG-1:0] SEL_OFF = 6'h3F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } scan_st_t;

  typedef struct packed {
    logic       dp;
    logic [3:0] nib;
  } digit_t;

  function automatic logic [NUM_DIG-1:0] sel_onecold(
    input logic [2:0] idx
  );
    logic [NUM_DIG-1:0] s;
    for (int i = 0; i < NUM_DIG; i++) begin
      s[i] = (idx != 3'(i));
    end
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex.sv
// Hex nibble plus decimal point to active-low {dp,g..a} segments.
// Purely combinational; common-anode polarity.
import seg_scan_ctrl_pkg::*;

module seg_hex_decoder (
  input  digit_t      dig,
  output logic [7:0]  seg
);

  logic [6:0] seg7;

  always_comb begin
    seg7 = 7'h7F;
    unique case (dig.nib)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
    endcase
    seg = {~dig.dp, seg7};
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit seven-segment scan scheduler with double-buffered digit
// store, frame-aligned commit, dead-time blanking and zero suppression.
import seg_scan_ctrl_pkg::*;

module seg_scan_ctrl #(
  parameter int SLOT_CYC  = 50_000,
  parameter int BLANK_CYC = 500
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [2:0]         wr_addr,
  input  logic [3:0]         wr_data,
  input  logic               wr_dp,
  input  logic               commit,
  input  logic               lz_en,
  output logic               commit_done,
  output logic               frame_start,
  output logic [NUM_DIG-1:0] seg_sel,
  output logic [7:0]         seg_led
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] CNT_BLNK = CW'(BLANK_CYC);
  localparam logic [2:0] IDX_LAST = 3'(NUM_DIG - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx_q;
  logic [2:0]    idx_d;
  scan_st_t      st_q;
  scan_st_t      st_d;

  digit_t [NUM_DIG-1:0] shadow_q;
  digit_t [NUM_DIG-1:0] active_q;

  logic pend_q;
  logic lz_q;
  logic slot_end;
  logic boundary;
  logic wr_fire;
  logic run;

  logic [NUM_DIG-1:0] lz_blank;
  digit_t             cur;
  logic [7:0]         cur_seg;

  assign slot_end = (cnt_q == CNT_LAST);
  assign boundary = slot_end && (idx_q == IDX_LAST);
  assign wr_ready = !boundary;
  assign wr_fire  = wr_valid && wr_ready
                 && (wr_addr < 3'(NUM_DIG));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (1'b1)
      (cnt_d < CNT_BLNK): st_d = ST_BLANK;
      default:            st_d = ST_ON;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      st_q  <= ST_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      st_q  <= st_d;
    end
  end

  // Boundary cycle never accepts writes, so the copy sees a stable shadow.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      active_q    <= '0;
      pend_q      <= 1'b0;
      commit_done <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (wr_fire) begin
        shadow_q[wr_addr] <= '{dp: wr_dp, nib: wr_data};
      end
      if (boundary && pend_q) begin
        active_q <= shadow_q;
      end
      if (commit) begin
        pend_q <= 1'b1;
      end else if (boundary) begin
        pend_q <= 1'b0;
      end
      commit_done <= boundary && pend_q;
      frame_start <= boundary;
    end
  end

  always_comb begin
    lz_blank = '0;
    run      = 1'b1;
    for (int k = NUM_DIG - 1; k >= 1; k--) begin
      run         = run && (active_q[k] == '0);
      lz_blank[k] = run;
    end
  end

  assign cur = active_q[idx_q];

  seg_hex_decoder u_dec (
    .dig (cur),
    .seg (cur_seg)
  );

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      lz_q    <= 1'b0;
      seg_sel <= SEL_OFF;
      seg_led <= SEG_OFF;
    end else begin
      if (slot_end) begin
        lz_q <= lz_en;
      end
      if (st_q == ST_ON) begin
        seg_sel <= sel_onecold(idx_q);
        seg_led <= (lz_q && lz_blank[idx_q])
                 ? SEG_OFF : cur_seg;
      end else begin
        seg_sel <= SEL_OFF;
        seg_led <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: per-cycle scoreboard against a reference
// model, a table of digit vectors, and directed commit/reset sequences.
module tb_seg_scan_ctrl;

  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int FRAME = 60;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = 3'd0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_dp = 1'b0;
  logic       commit = 1'b0;
  logic       lz_en = 1'b0;
  logic       commit_done;
  logic       frame_start;
  logic [5:0] seg_sel;
  logic [7:0] seg_led;

  always #10 clk_50M = ~clk_50M;

  seg_scan_ctrl #(
    .SLOT_CYC  (SLOT),
    .BLANK_CYC (BLANK)
  ) dut (
    .clk_50M     (clk_50M),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_dp       (wr_dp),
    .commit      (commit),
    .lz_en       (lz_en),
    .commit_done (commit_done),
    .frame_start (frame_start),
    .seg_sel     (seg_sel),
    .seg_led     (seg_led)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dec(input logic dp, input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;
      4'h3: s = 7'h30;  4'h4: s = 7'h19;  4'h5: s = 7'h12;
      4'h6: s = 7'h02;  4'h7: s = 7'h78;  4'h8: s = 7'h00;
      4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return {~dp, s};
  endfunction

  int       m_cnt;
  int       m_idx;
  logic     m_pend;
  logic     m_lz;
  logic [4:0] m_sh [6];
  logic [4:0] m_act [6];

  typedef struct packed {
    logic [5:0] sel;
    logic [7:0] led;
    logic       fs;
    logic       cd;
  } exp_t;

  exp_t sbq [$];

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    m_pend = 1'b0;
    m_lz = 1'b0;
    for (int j = 0; j < 6; j++) begin
      m_sh[j] = '0;
      m_act[j] = '0;
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    bit on;
    bit blank;
    on = (m_cnt >= BLANK);
    blank = m_lz && (m_idx != 0);
    for (int j = m_idx; j < 6; j++) begin
      if (m_act[j] != 0) blank = 0;
    end
    e.sel = on ? ~(6'b1 << m_idx) : 6'h3F;
    e.led = (on && !blank) ? dec(m_act[m_idx][4], m_act[m_idx][3:0])
                           : 8'hFF;
    e.fs = (m_cnt == SLOT - 1) && (m_idx == 5);
    e.cd = e.fs && m_pend;
    return e;
  endfunction

  task automatic model_step();
    bit bnd;
    bnd = (m_cnt == SLOT - 1) && (m_idx == 5);
    if (wr_valid && !bnd && wr_addr < 6) m_sh[wr_addr] = {wr_dp, wr_data};
    if (bnd && m_pend) begin
      for (int j = 0; j < 6; j++) m_act[j] = m_sh[j];
    end
    if (commit) m_pend = 1'b1;
    else if (bnd) m_pend = 1'b0;
    if (m_cnt == SLOT - 1) begin
      m_lz = lz_en;
      m_cnt = 0;
      m_idx = (m_idx == 5) ? 0 : m_idx + 1;
    end else begin
      m_cnt++;
    end
  endtask

  always @(posedge clk_50M) begin : mon
    exp_t e;
    #1;
    if (!rst_n) begin
      model_reset();
      sbq.delete();
      chk("rst_sel", seg_sel, 6'h3F);
      chk("rst_led", seg_led, 8'hFF);
      sbq.push_back(predict());
    end else begin
      if (sbq.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("sb_sel", seg_sel, e.sel);
        chk("sb_led", seg_led, e.led);
        chk("sb_fs", frame_start, e.fs);
        chk("sb_cd", commit_done, e.cd);
      end
      model_step();
      chk("sb_wr_ready", wr_ready,
          !((m_cnt == SLOT - 1) && (m_idx == 5)));
      sbq.push_back(predict());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d,
                    input logic dp, input bit with_commit);
    bit done;
    @(negedge clk_50M);
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_dp = dp;
    commit = with_commit;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (wr_ready) done = 1;
      @(negedge clk_50M);
    end
    wr_valid = 1'b0;
    commit = 1'b0;
    if (!done) chk("wr_timeout", 0, 1);
  endtask

  task automatic pulse_commit();
    @(negedge clk_50M);
    commit = 1'b1;
    @(negedge clk_50M);
    commit = 1'b0;
  endtask

  task automatic wait_cd(input string name);
    bit ok;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk_50M);
      if (commit_done) ok = 1;
    end
    chk({name, "_cd_seen"}, ok, 1);
    @(negedge clk_50M);
    chk({name, "_cd_width"}, commit_done, 0);
  endtask

  task automatic wait_fs();
    bit ok;
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk_50M);
      if (frame_start) ok = 1;
    end
    if (!ok) chk("fs_timeout", 0, 1);
  endtask

  task automatic wait_digit(input int k, output bit ok);
    logic [5:0] want;
    want = ~(6'b1 << k);
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk_50M);
      if (seg_sel == want) ok = 1;
    end
  endtask

  task automatic check_digit(input string name, input int k,
                             input logic [7:0] exp);
    bit ok;
    wait_digit(k, ok);
    if (ok) chk(name, seg_led, exp);
    else chk({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [3:0] data;
    logic       dp;
    logic [7:0] led;
  } vec_t;

  vec_t tbl [18];

  initial begin : wdog
    #600_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit ok;
    int zeros;
    bit acc;
    bit cd_seen;
    int cd_cnt;

    tbl[0]  = '{3'd0, 4'h1, 1'b0, 8'hF9};
    tbl[1]  = '{3'd1, 4'h2, 1'b0, 8'hA4};
    tbl[2]  = '{3'd2, 4'h3, 1'b0, 8'hB0};
    tbl[3]  = '{3'd3, 4'h4, 1'b0, 8'h99};
    tbl[4]  = '{3'd4, 4'h5, 1'b0, 8'h92};
    tbl[5]  = '{3'd5, 4'h6, 1'b0, 8'h82};
    tbl[6]  = '{3'd0, 4'hA, 1'b1, 8'h08};
    tbl[7]  = '{3'd1, 4'hB, 1'b0, 8'h83};
    tbl[8]  = '{3'd2, 4'hC, 1'b0, 8'hC6};
    tbl[9]  = '{3'd3, 4'hD, 1'b1, 8'h21};
    tbl[10] = '{3'd4, 4'hE, 1'b0, 8'h86};
    tbl[11] = '{3'd5, 4'hF, 1'b0, 8'h8E};
    tbl[12] = '{3'd0, 4'h7, 1'b0, 8'hF8};
    tbl[13] = '{3'd1, 4'h8, 1'b0, 8'h80};
    tbl[14] = '{3'd2, 4'h9, 1'b0, 8'h90};
    tbl[15] = '{3'd3, 4'h0, 1'b1, 8'h40};
    tbl[16] = '{3'd4, 4'h1, 1'b0, 8'hF9};
    tbl[17] = '{3'd5, 4'h2, 1'b0, 8'hA4};

    cyc(3);
    chk("reset_sel", seg_sel, 6'h3F);
    chk("reset_led", seg_led, 8'hFF);
    chk("reset_ready", wr_ready, 1);
    chk("reset_cd", commit_done, 0);
    chk("reset_fs", frame_start, 0);
    rst_n = 1'b1;

    check_digit("init_d0", 0, 8'hC0);
    check_digit("init_d3", 3, 8'hC0);
    check_digit("init_d5", 5, 8'hC0);

    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 6; i++) begin
        wr(tbl[g*6+i].addr, tbl[g*6+i].data, tbl[g*6+i].dp, i == 5);
      end
      wait_cd($sformatf("grp%0d", g));
      for (int i = 0; i < 6; i++) begin
        check_digit($sformatf("tbl%0d", g*6+i), int'(tbl[g*6+i].addr),
                    tbl[g*6+i].led);
      end
    end

    wr(3'd5, 4'h0, 1'b0, 0);
    wr(3'd4, 4'h0, 1'b0, 0);
    wr(3'd3, 4'h4, 1'b0, 0);
    wr(3'd2, 4'h0, 1'b0, 0);
    wr(3'd1, 4'h0, 1'b0, 0);
    wr(3'd0, 4'h7, 1'b0, 1);
    wait_cd("lz");
    lz_en = 1'b1;
    cyc(FRAME);
    check_digit("lz_d5", 5, 8'hFF);
    check_digit("lz_d4", 4, 8'hFF);
    check_digit("lz_d3", 3, 8'h99);
    check_digit("lz_d2", 2, 8'hC0);
    check_digit("lz_d1", 1, 8'hC0);
    check_digit("lz_d0", 0, 8'hF8);

    wait_fs();
    pulse_commit();
    cyc(57);
    wr_valid = 1'b1;
    wr_addr = 3'd1;
    wr_data = 4'h9;
    wr_dp = 1'b0;
    zeros = 0;
    acc = 0;
    cd_seen = 0;
    for (int k = 0; k < 5 && !acc; k++) begin
      if (wr_ready) acc = 1;
      else zeros++;
      if (commit_done) cd_seen = 1;
      @(negedge clk_50M);
    end
    wr_valid = 1'b0;
    chk("bnd_ready_zeros", zeros, 1);
    chk("bnd_accepted", acc, 1);
    chk("bnd_commit_done", cd_seen, 1);
    check_digit("bnd_old_d1", 1, 8'hC0);
    pulse_commit();
    wait_cd("bnd2");
    check_digit("bnd_new_d1", 1, 8'h90);

    wr(3'd6, 4'h5, 1'b0, 1);
    wait_cd("addr6");
    check_digit("addr6_d0", 0, 8'hF8);
    check_digit("addr6_d3", 3, 8'h99);

    wait_fs();
    wr(3'd0, 4'h3, 1'b0, 1);
    wait_digit(3, ok);
    chk("rst_mid_d3_on", ok, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sel", seg_sel, 6'h3F);
    chk("rst_mid_led", seg_led, 8'hFF);
    chk("rst_mid_cd", commit_done, 0);
    chk("rst_mid_ready", wr_ready, 1);
    cyc(3);
    rst_n = 1'b1;
    cd_cnt = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk_50M);
      if (commit_done) cd_cnt++;
    end
    chk("rst_no_commit_done", cd_cnt, 0);
    check_digit("rst_after_d0", 0, 8'hC0);
    check_digit("rst_after_d1", 1, 8'hFF);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
